// File: rtl/fcc_point_streamer.sv
// Range-image frame buffer that streams every cell, in raster order, to the FCC clustering core.
// Optional macro FCC_ZERO_AS_GROUND_EN: also flag all-zero (no-return) points as ground.
module fcc_point_streamer #(
    parameter int W        = 16,
    parameter int ROWS     = 30,
    parameter int COLS     = 30,
    parameter int ROW_W    = 8,
    parameter int COL_W    = 5,
    parameter int ADDR_W   = 10,
    parameter int GROUND_Z = -100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_we,
    input  logic [ROW_W-1:0]        ld_row,
    input  logic [COL_W-1:0]        ld_col,
    input  logic signed [W-1:0]     ld_x,
    input  logic signed [W-1:0]     ld_y,
    input  logic signed [W-1:0]     ld_z,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ROW_W-1:0]        out_row,
    output logic [COL_W-1:0]        out_col,
    output logic signed [W-1:0]     out_x,
    output logic signed [W-1:0]     out_y,
    output logic signed [W-1:0]     out_z,
    output logic                    out_is_ground,
    output logic                    out_last
);

    localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]    LAST_COL = COL_W'(COLS - 1);
    localparam logic signed [W-1:0] GZ       = W'(GROUND_Z);
`ifdef FCC_ZERO_AS_GROUND_EN
    localparam bit ZERO_GND = 1'b1;
`else
    localparam bit ZERO_GND = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RD, SEND} state_t;

    state_t             state;
    logic [ROW_W-1:0]   row_p0;
    logic [COL_W-1:0]   col_p0;
    logic [3*W-1:0]     mem [ROWS*COLS];
    logic [3*W-1:0]     rd_word;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    function automatic logic is_ground(input logic [3*W-1:0] word);
        logic signed [W-1:0] z;
        z = word[W-1:0];
        return (z <= GZ) || (ZERO_GND && (word == '0));
    endfunction

    // Frame buffer: stored as {x, y, z}; out-of-range and mid-stream loads are dropped
    always_ff @(posedge clk) begin
        if (state == IDLE && ld_we && ld_row <= LAST_ROW && ld_col <= LAST_COL)
            mem[cell_addr(ld_row, ld_col)] <= {ld_x, ld_y, ld_z};
    end

    assign rd_word = mem[cell_addr(row_p0, col_p0)];

    // RD registers the cursor cell into the beat registers; SEND holds them until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            row_p0        <= '0;
            col_p0        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_is_ground <= 1'b0;
            out_row       <= '0;
            out_col       <= '0;
            out_x         <= '0;
            out_y         <= '0;
            out_z         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RD;
                        busy   <= 1'b1;
                        row_p0 <= '0;
                        col_p0 <= '0;
                    end
                end
                RD: begin
                    out_row       <= row_p0;
                    out_col       <= col_p0;
                    out_x         <= rd_word[3*W-1:2*W];
                    out_y         <= rd_word[2*W-1:W];
                    out_z         <= rd_word[W-1:0];
                    out_is_ground <= is_ground(rd_word);
                    out_last      <= (row_p0 == LAST_ROW) && (col_p0 == LAST_COL);
                    out_valid     <= 1'b1;
                    state         <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            if (col_p0 == LAST_COL) begin
                                col_p0 <= '0;
                                row_p0 <= row_p0 + 1'b1;
                            end else begin
                                col_p0 <= col_p0 + 1'b1;
                            end
                            state <= RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcc_point_streamer.sv
// Directed bench for fcc_point_streamer: full-frame streams, stalls, dropped loads, mid-stream reset.
module tb_fcc_point_streamer;

    logic               clk = 1'b0;
    logic               rst;
    logic               ld_we;
    logic [7:0]         ld_row;
    logic [4:0]         ld_col;
    logic signed [15:0] ld_x, ld_y, ld_z;
    logic               start;
    logic               busy, done, out_valid, out_ready;
    logic [7:0]         out_row;
    logic [4:0]         out_col;
    logic signed [15:0] out_x, out_y, out_z;
    logic               out_is_ground, out_last;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] mx [900];
    logic signed [15:0] my [900];
    logic signed [15:0] mz [900];

`ifdef FCC_ZERO_AS_GROUND_EN
    localparam bit ZG = 1'b1;
`else
    localparam bit ZG = 1'b0;
`endif

    always #5 clk = ~clk;

    fcc_point_streamer dut (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_row(ld_row), .ld_col(ld_col),
        .ld_x(ld_x), .ld_y(ld_y), .ld_z(ld_z), .start(start), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_is_ground(out_is_ground),
        .out_last(out_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_vec();
        return {out_valid, out_row, out_col, out_x, out_y, out_z, out_is_ground, out_last};
    endfunction

    function automatic logic [63:0] exp_vec(input int i);
        logic gnd;
        gnd = (mz[i] <= -16'sd100) || (ZG && mx[i] == 0 && my[i] == 0 && mz[i] == 0);
        return {1'b1, 8'(i / 30), 5'(i % 30), mx[i], my[i], mz[i], gnd, (i == 899)};
    endfunction

    task automatic load(input int r, input int c, input logic signed [15:0] x,
                        input logic signed [15:0] y, input logic signed [15:0] z);
        ld_we = 1'b1; ld_row = 8'(r); ld_col = 5'(c); ld_x = x; ld_y = y; ld_z = z;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic kick(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ld_we = 1'b0;
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        chk({tag, "_valid_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_valid_lat2"}, 64'(out_valid), 64'd1);
    endtask

    // Called at posedge+1 with the stream running; returns when done is seen, reset is applied, or the budget expires.
    task automatic run_stream(input string tag, input bit stall, input int start_at,
                              input int ld_at, input int rst_at, output int nbeats);
        logic [63:0] held;
        bit holding, aborted, rdy;
        nbeats = 0; holding = 0; aborted = 0;
        for (int cyc = 0; cyc < 4000 && !done && !aborted; cyc++) begin
            if (holding) chk({tag, "_stall_hold"}, beat_vec(), held);
            holding = 0;
            if (rst_at >= 0 && nbeats == rst_at) begin
                out_ready = 1'b0; rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk({tag, "_rst_valid"}, 64'(out_valid), 64'd0);
                chk({tag, "_rst_busy"}, 64'(busy), 64'd0);
                aborted = 1;
            end else begin
                start = (cyc == start_at);
                ld_we = (cyc == ld_at);
                ld_row = 8'd2; ld_col = 5'd2;
                ld_x = 16'sh7777; ld_y = 16'sh7777; ld_z = -16'sd7777;
                rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                out_ready = rdy;
                if (out_valid) begin
                    if (rdy) begin
                        chk({tag, "_beat"}, beat_vec(), exp_vec(nbeats));
                        nbeats++;
                    end else begin
                        holding = 1;
                        held = beat_vec();
                    end
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        ld_we = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic finish_checks(input string tag, input int nbeats);
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_beats"}, 64'(nbeats), 64'd900);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, "_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int nb;
        rst = 1'b1; ld_we = 1'b0; ld_row = '0; ld_col = '0;
        ld_x = '0; ld_y = '0; ld_z = '0; start = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, out_valid, out_last, out_is_ground},
            64'd0);
        chk("reset_data", {out_row, out_col, out_x, out_y, out_z}, 64'd0);
        rst = 1'b0;

        // Frame: distinct x/y, z=0, plus ground-threshold and no-return cells
        for (int i = 0; i < 900; i++) begin
            mx[i] = 16'(i + 1);
            my[i] = 16'(-(i + 1));
            mz[i] = 16'sd0;
        end
        mz[3*30+7] = -16'sd100;
        mz[3*30+8] = -16'sd99;
        mx[5*30+5] = 16'sd0;
        my[5*30+5] = 16'sd0;
        for (int i = 0; i < 900; i++) load(i / 30, i % 30, mx[i], my[i], mz[i]);
        load(30, 0, 16'sh7fff, 16'sh7fff, 16'sh7fff);
        load(0, 31, 16'sh7fff, 16'sh7fff, 16'sh7fff);
        load(1, 30, 16'sh7fff, 16'sh7fff, 16'sh7fff);
        chk("idle_busy", 64'(busy), 64'd0);

        // Pass A: free-flowing sink, a redundant start mid-stream
        kick("a");
        run_stream("a", 1'b0, 301, -1, -1, nb);
        finish_checks("a", nb);

        // Pass B: load coincident with start, random stalls, a load attempt while busy
        mx[0] = 16'sh1234; my[0] = 16'sh2345; mz[0] = -16'sd300;
        ld_we = 1'b1; ld_row = 8'd0; ld_col = 5'd0;
        ld_x = mx[0]; ld_y = my[0]; ld_z = mz[0];
        kick("b");
        run_stream("b", 1'b1, -1, 50, -1, nb);
        finish_checks("b", nb);

        // Pass C: reset after 100 beats, no done afterwards
        kick("c");
        run_stream("c", 1'b0, -1, -1, 100, nb);
        chk("c_rst_beats", 64'(nb), 64'd100);
        for (int k = 0; k < 4; k++) begin
            chk("c_no_done", {done, out_valid, busy}, 64'd0);
            @(posedge clk); #1;
        end

        // Pass D: restart after reset streams from (0,0) with the retained frame
        kick("d");
        run_stream("d", 1'b1, -1, -1, -1, nb);
        finish_checks("d", nb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
